spi_cmd_regfile: RTL and testbench
==================================

// Module: spi_cmd_regfile
// PURPOSE
//   Command decoder/register bank directly downstream of SPI_slave_interface. Consumes each
//   received SPI word, decodes it as a register read/write, drives config/control outputs to the
//   DFT core, and loads the read response into the word returned on the next SPI frame. Holds a
//   small sample FIFO, filled by the DFT core and drained by SPI reads of FIFO_DATA.
// PARAMETERS
//   DATA_W      16      SPI word width; SPI_slave_interface is instantiated with spi_s_width=DATA_W
//   FIFO_DEPTH  16      sample FIFO entries, power of 2, >=2
//   ID_VALUE    12'hD1F constant returned by ID register
//   CFG_A_RST   12'h000 reset value of CFG_A
//   CFG_B_RST   12'h000 reset value of CFG_B
// PORTS
//   i_sys_clk      in   1       system clock; only clock in the block
//   i_sys_rst      in   1       synchronous, active-high reset
//   i_rx_data      in   DATA_W  received word (SPI interface o_data)
//   i_rx_valid     in   1       1-cycle strobe, i_rx_data valid (SPI interface o_data_ready)
//   o_tx_data      out  DATA_W  response word (to SPI interface i_data), held stable between updates
//   o_enable       out  1       CTRL[1] level
//   o_start        out  1       1-cycle pulse on write of CTRL[0]=1
//   o_cfg_a        out  12      CFG_A register
//   o_cfg_b        out  12      CFG_B register
//   i_sample       in   12      sample from DFT core
//   i_sample_valid in   1       push strobe for i_sample
//   o_fifo_full    out  1       FIFO count == FIFO_DEPTH
//   o_fifo_ovf     out  1       sticky: push dropped while full
// BEHAVIOUR
//   Reset: o_tx_data=0, o_enable=0, o_start=0, o_cfg_a=CFG_A_RST, o_cfg_b=CFG_B_RST, FIFO empty
//     (count 0, pointers 0), o_fifo_full=0, o_fifo_ovf=0. Reset mid-operation discards FIFO contents.
//   Command word: [15]=1 write/0 read, [14:12]=addr, [11:0]=payload. Decoded only when i_rx_valid=1.
//   Register map (12-bit):
//     0 CTRL   RW  [1]=enable, [0]=start (write-1 pulses o_start, reads 0), [11:2] read 0
//     1 CFG_A  RW;  2 CFG_B  RW
//     3 STATUS RO  [11]=ovf, [10]=full, [9]=empty, [8:0]=count (zero-ext); write with payload[11]=1
//              clears ovf (the clear wins over a same-cycle ovf set), all other writes ignored
//     4 ID     RO  ID_VALUE;  5,6 reserved: read 0, writes ignored
//     7 FIFO   RO  read pops one entry, returns it; empty -> returns 0, no pop; writes ignored
//   Latency: command on cycle N (i_rx_valid) -> register/o_start/o_tx_data update visible cycle N+1.
//   o_start high exactly cycle N+1, low otherwise.
//   o_tx_data on read: {1'b0, addr, rdata}; on write: {1'b1, addr, new register value (reads as
//     above)}. o_tx_data changes only at N+1 of a command; holds otherwise (SPI IF samples it freely).
//   FIFO push: when i_sample_valid; accepted if count<FIFO_DEPTH OR a pop occurs the same cycle.
//     Rejected push sets o_fifo_ovf (sticky until STATUS clear or reset), data dropped.
//   Simultaneous push+pop: full -> count unchanged, both performed; empty -> pop returns 0, push
//     accepted, count=1. Pointers wrap modulo FIFO_DEPTH; count has log2(FIFO_DEPTH)+1 bits.
//   o_fifo_full registered, consistent with count in the same cycle.
//   Back-to-back i_rx_valid on consecutive cycles each fully processed in order.
// TESTING
//   Reset, then read ID (rx 0x4000) -> next cycle o_tx_data=0x4D1F; all other outputs at reset values.
//   Write CFG_A (rx 0x9ABC) -> o_cfg_a=0xABC, o_tx_data=0x9ABC; read back 0x1000 -> o_tx_data=0x1ABC.
//   Write CTRL 0x8003 -> o_enable=1, o_start high exactly 1 cycle; read CTRL -> o_tx_data=0x0002.
//   Push 0x111,0x222,0x333; read 0x7000 x4 -> tx 0x7111,0x7222,0x7333, then 0x7000 (empty, count 0).
//   Push 17 samples (DEPTH 16) -> full=1, ovf=1, STATUS read 0x3C10; write 0xB800 -> ovf=0.
//   Full FIFO, pop and push same cycle -> count stays 16, ovf stays 0, order preserved across wrap.

Source files
------------

// File: rtl/spi_cmd_regfile.sv
// SPI command decoder and register bank: decodes received words as register reads/writes,
// drives DFT core configuration, and queues DFT samples in a small FIFO drained by SPI reads.
module spi_cmd_regfile #(
    parameter int          DATA_W     = 16,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [11:0] ID_VALUE   = 12'hD1F,
    parameter logic [11:0] CFG_A_RST  = 12'h000,
    parameter logic [11:0] CFG_B_RST  = 12'h000
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_enable,
    output logic              o_start,
    output logic [11:0]       o_cfg_a,
    output logic [11:0]       o_cfg_b,
    input  logic [11:0]       i_sample,
    input  logic              i_sample_valid,
    output logic              o_fifo_full,
    output logic              o_fifo_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_CFG_A  = 3'd1;
    localparam logic [2:0] A_CFG_B  = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_ID     = 3'd4;
    localparam logic [2:0] A_FIFO   = 3'd7;

    // Handshake: i_rx_valid and i_sample_valid are single-cycle strobes with no ready/backpressure;
    // every strobed word is consumed that cycle, and a sample that cannot be stored is dropped and flagged.

    logic          cmd_wr;
    logic [2:0]    cmd_addr;
    logic [11:0]   cmd_payload;

    logic [11:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          fifo_empty;
    logic [11:0]   fifo_head;

    logic          pop;
    logic          push_ok;
    logic          ovf_clear;
    logic [11:0]   status_val;
    logic [11:0]   rd_val;
    logic [11:0]   wr_val;
    logic [11:0]   resp_val;

    assign cmd_wr      = i_rx_data[DATA_W-1];
    assign cmd_addr    = i_rx_data[DATA_W-2 -: 3];
    assign cmd_payload = i_rx_data[11:0];

    assign fifo_empty = (count == '0);
    assign fifo_head  = fifo_empty ? 12'h000 : fifo_mem[rd_ptr];
    assign status_val = {o_fifo_ovf, o_fifo_full, fifo_empty, 9'(count)};

    assign pop       = i_rx_valid && !cmd_wr && (cmd_addr == A_FIFO) && !fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push_ok   = i_sample_valid && ((count < DEPTH_C) || pop);
    assign ovf_clear = i_rx_valid && cmd_wr && (cmd_addr == A_STATUS) && cmd_payload[11];

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        rd_val = 12'h000;
        case (cmd_addr)
            A_CTRL:   rd_val = {10'd0, o_enable, 1'b0};
            A_CFG_A:  rd_val = o_cfg_a;
            A_CFG_B:  rd_val = o_cfg_b;
            A_STATUS: rd_val = status_val;
            A_ID:     rd_val = ID_VALUE;
            A_FIFO:   rd_val = fifo_head;
            default:  rd_val = 12'h000;
        endcase
    end

    // Write response echoes the register value after the write takes effect.
    always_comb begin
        wr_val = 12'h000;
        case (cmd_addr)
            A_CTRL:   wr_val = {10'd0, cmd_payload[1], 1'b0};
            A_CFG_A:  wr_val = cmd_payload;
            A_CFG_B:  wr_val = cmd_payload;
            A_STATUS: wr_val = {o_fifo_ovf & ~cmd_payload[11], status_val[10:0]};
            A_ID:     wr_val = ID_VALUE;
            default:  wr_val = 12'h000;
        endcase
    end

    assign resp_val = cmd_wr ? wr_val : rd_val;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            o_tx_data <= '0;
            o_enable  <= 1'b0;
            o_start   <= 1'b0;
            o_cfg_a   <= CFG_A_RST;
            o_cfg_b   <= CFG_B_RST;
        end else begin
            o_start <= 1'b0;
            if (i_rx_valid) begin
                o_tx_data <= DATA_W'({cmd_wr, cmd_addr, resp_val});
                if (cmd_wr) begin
                    case (cmd_addr)
                        A_CTRL: begin
                            o_enable <= cmd_payload[1];
                            o_start  <= cmd_payload[0];
                        end
                        A_CFG_A: o_cfg_a <= cmd_payload;
                        A_CFG_B: o_cfg_b <= cmd_payload;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            o_fifo_full <= 1'b0;
            o_fifo_ovf  <= 1'b0;
        end else begin
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            count       <= count_nxt;
            o_fifo_full <= (count_nxt == DEPTH_C);
            // Clear has priority over a rejected push in the same cycle.
            if (ovf_clear)
                o_fifo_ovf <= 1'b0;
            else if (i_sample_valid && !push_ok)
                o_fifo_ovf <= 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= i_sample;
    end

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Directed bench for spi_cmd_regfile: register access, CTRL start pulse, FIFO ordering,
// overflow flag handling and full-FIFO simultaneous push/pop.
module tb_spi_cmd_regfile;
    logic        i_sys_clk;
    logic        i_sys_rst;
    logic [15:0] i_rx_data;
    logic        i_rx_valid;
    logic [15:0] o_tx_data;
    logic        o_enable;
    logic        o_start;
    logic [11:0] o_cfg_a;
    logic [11:0] o_cfg_b;
    logic [11:0] i_sample;
    logic        i_sample_valid;
    logic        o_fifo_full;
    logic        o_fifo_ovf;

    int checks;
    int errors;

    spi_cmd_regfile dut (
        .i_sys_clk      (i_sys_clk),
        .i_sys_rst      (i_sys_rst),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_tx_data      (o_tx_data),
        .o_enable       (o_enable),
        .o_start        (o_start),
        .o_cfg_a        (o_cfg_a),
        .o_cfg_b        (o_cfg_b),
        .i_sample       (i_sample),
        .i_sample_valid (i_sample_valid),
        .o_fifo_full    (o_fifo_full),
        .o_fifo_ovf     (o_fifo_ovf)
    );

    initial i_sys_clk = 1'b0;
    always #5 i_sys_clk = ~i_sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle command; returns at the falling edge after the capturing rising edge.
    task automatic cmd(input logic [15:0] w);
        @(negedge i_sys_clk);
        i_rx_data  = w;
        i_rx_valid = 1'b1;
        @(negedge i_sys_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic push(input logic [11:0] s);
        @(negedge i_sys_clk);
        i_sample       = s;
        i_sample_valid = 1'b1;
        @(negedge i_sys_clk);
        i_sample_valid = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        i_sys_rst      = 1'b1;
        i_rx_data      = '0;
        i_rx_valid     = 1'b0;
        i_sample       = '0;
        i_sample_valid = 1'b0;
        repeat (3) @(negedge i_sys_clk);
        i_sys_rst = 1'b0;

        chk("rst_tx", 32'(o_tx_data), 32'h0000);
        chk("rst_enable", 32'(o_enable), 32'h0);
        chk("rst_start", 32'(o_start), 32'h0);
        chk("rst_cfg_a", 32'(o_cfg_a), 32'h000);
        chk("rst_cfg_b", 32'(o_cfg_b), 32'h000);
        chk("rst_full", 32'(o_fifo_full), 32'h0);
        chk("rst_ovf", 32'(o_fifo_ovf), 32'h0);

        cmd(16'h4000);
        chk("id_read", 32'(o_tx_data), 32'h4D1F);
        chk("id_cfg_a_unchanged", 32'(o_cfg_a), 32'h000);

        cmd(16'h9ABC);
        chk("cfg_a_write", 32'(o_cfg_a), 32'hABC);
        chk("cfg_a_write_tx", 32'(o_tx_data), 32'h9ABC);
        cmd(16'h1000);
        chk("cfg_a_read", 32'(o_tx_data), 32'h1ABC);

        cmd(16'hA123);
        chk("cfg_b_write", 32'(o_cfg_b), 32'h123);
        chk("cfg_b_write_tx", 32'(o_tx_data), 32'hA123);

        cmd(16'h8003);
        chk("ctrl_enable", 32'(o_enable), 32'h1);
        chk("ctrl_start_pulse", 32'(o_start), 32'h1);
        chk("ctrl_write_tx", 32'(o_tx_data), 32'h8002);
        @(negedge i_sys_clk);
        chk("ctrl_start_low", 32'(o_start), 32'h0);
        chk("tx_hold", 32'(o_tx_data), 32'h8002);
        cmd(16'h0000);
        chk("ctrl_read", 32'(o_tx_data), 32'h0002);
        chk("ctrl_read_no_start", 32'(o_start), 32'h0);

        cmd(16'h3000);
        chk("status_empty", 32'(o_tx_data), 32'h3200);

        cmd(16'h5000);
        chk("reserved_read", 32'(o_tx_data), 32'h5000);
        cmd(16'hD555);
        chk("reserved_write", 32'(o_tx_data), 32'hD000);
        cmd(16'hC777);
        chk("id_write_ignored", 32'(o_tx_data), 32'hCD1F);

        // Back-to-back commands on consecutive cycles.
        @(negedge i_sys_clk);
        i_rx_data  = 16'h9001;
        i_rx_valid = 1'b1;
        @(negedge i_sys_clk);
        i_rx_data  = 16'hA002;
        @(negedge i_sys_clk);
        i_rx_valid = 1'b0;
        chk("b2b_cfg_a", 32'(o_cfg_a), 32'h001);
        chk("b2b_cfg_b", 32'(o_cfg_b), 32'h002);
        chk("b2b_tx", 32'(o_tx_data), 32'hA002);

        push(12'h111);
        push(12'h222);
        push(12'h333);
        cmd(16'h3000);
        chk("status_three", 32'(o_tx_data), 32'h3003);
        cmd(16'h7000);
        chk("fifo_pop0", 32'(o_tx_data), 32'h7111);
        cmd(16'h7000);
        chk("fifo_pop1", 32'(o_tx_data), 32'h7222);
        cmd(16'h7000);
        chk("fifo_pop2", 32'(o_tx_data), 32'h7333);
        cmd(16'h7000);
        chk("fifo_pop_empty", 32'(o_tx_data), 32'h7000);
        cmd(16'h3000);
        chk("status_drained", 32'(o_tx_data), 32'h3200);

        // 17 consecutive pushes into a 16-deep FIFO: the last is dropped.
        for (int i = 0; i < 17; i++) begin
            @(negedge i_sys_clk);
            i_sample       = 12'(12'h100 + i);
            i_sample_valid = 1'b1;
        end
        @(negedge i_sys_clk);
        i_sample_valid = 1'b0;
        chk("overflow_full", 32'(o_fifo_full), 32'h1);
        chk("overflow_ovf", 32'(o_fifo_ovf), 32'h1);
        cmd(16'h3000);
        chk("status_full_ovf", 32'(o_tx_data), 32'h3C10);
        cmd(16'hB000);
        chk("status_write_no_clear", 32'(o_fifo_ovf), 32'h1);
        cmd(16'hB800);
        chk("status_clear_ovf", 32'(o_fifo_ovf), 32'h0);
        chk("status_clear_tx", 32'(o_tx_data), 32'hB410);
        chk("status_clear_full", 32'(o_fifo_full), 32'h1);

        // Pop and push together while full.
        @(negedge i_sys_clk);
        i_rx_data      = 16'h7000;
        i_rx_valid     = 1'b1;
        i_sample       = 12'h200;
        i_sample_valid = 1'b1;
        @(negedge i_sys_clk);
        i_rx_valid     = 1'b0;
        i_sample_valid = 1'b0;
        chk("full_pushpop_tx", 32'(o_tx_data), 32'h7100);
        chk("full_pushpop_full", 32'(o_fifo_full), 32'h1);
        chk("full_pushpop_ovf", 32'(o_fifo_ovf), 32'h0);
        cmd(16'h3000);
        chk("full_pushpop_status", 32'(o_tx_data), 32'h3410);

        for (int i = 1; i < 16; i++) begin
            cmd(16'h7000);
            chk($sformatf("wrap_pop%0d", i), 32'(o_tx_data), 32'(16'h7100 + i));
        end
        cmd(16'h7000);
        chk("wrap_pop_last", 32'(o_tx_data), 32'h7200);
        chk("wrap_not_full", 32'(o_fifo_full), 32'h0);
        cmd(16'h3000);
        chk("status_final", 32'(o_tx_data), 32'h3200);

        // Reset mid-operation discards FIFO contents and restores registers.
        push(12'h0AA);
        @(negedge i_sys_clk);
        i_sys_rst = 1'b1;
        @(negedge i_sys_clk);
        i_sys_rst = 1'b0;
        chk("rst2_cfg_a", 32'(o_cfg_a), 32'h000);
        chk("rst2_enable", 32'(o_enable), 32'h0);
        cmd(16'h7000);
        chk("rst2_fifo_empty", 32'(o_tx_data), 32'h7000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
